// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the pc, drives the dual-port instruction RAM and hands instr/N/pc to the decoder.
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_en,
    input  logic        pc_sload,
    input  logic [15:0] new_pc,
    input  logic [15:0] instr_addr1,
    input  logic [15:0] instr_addr2,
    input  logic [15:0] imem_q1,
    input  logic [15:0] imem_q2,
    input  logic        stall,
    output logic [15:0] imem_addr1,
    output logic [15:0] imem_addr2,
    output logic [15:0] pc,
    output logic [15:0] instr,
    output logic [15:0] N,
    output logic        valid,
    output logic        halted,
    output logic [15:0] retired
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, hold1_q, hold1_d, hold2_q, hold2_d, retired_q, retired_d;
    logic        boot, go;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= BOOT;
            pc_q      <= 16'h0000;
            hold1_q   <= 16'h0000;
            hold2_q   <= 16'h0001;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold1_q   <= hold1_d;
            hold2_q   <= hold2_d;
            retired_q <= retired_d;
        end
    end
    // STP is recognised only on a valid cycle, so a stalled STP word waits for the RAM
    always_comb begin
        boot       = state_q == BOOT;
        go         = state_q == RUN && !stall;
        valid      = go;
        instr      = boot ? 16'h0000 : imem_q1;
        N          = boot ? 16'h0000 : imem_q2;
        state_d    = boot ? RUN : (go && imem_q1[15:11] == 5'b11111) ? HALT : state_q;
        hold1_d    = boot ? 16'h0000 : go ? instr_addr1 : hold1_q;
        hold2_d    = boot ? 16'h0001 : go ? instr_addr2 : hold2_q;
        imem_addr1 = boot ? 16'h0000 : go ? instr_addr1 : hold1_q;
        imem_addr2 = boot ? 16'h0001 : go ? instr_addr2 : hold2_q;
        pc_d       = boot ? 16'h0001 : !go ? pc_q : pc_sload ? new_pc : cnt_en ? pc_q + 16'h0001 : pc_q;
        retired_d  = (go && retired_q != 16'hFFFF) ? retired_q + 16'h0001 : retired_q;
    end
    assign pc      = pc_q;
    assign halted  = state_q == HALT;
    assign retired = retired_q;
endmodule
